// File: rtl/clock_text_overlay.sv
// clock_text_overlay
// Renders N_FIELDS two-digit BCD fields with colon separators ("hh:mm:ss" by
// default) at a fixed screen position and glyph scale. It produces the font ROM
// address, the glyph bit column, a colour index and a cell-valid flag, two
// clocks after the pixel coordinate is presented.
//
// The digits are snapshotted once per frame so the display never tears. The
// field under edit can blink.
//
// Ports:
//   clk         pixel clock
//   reset_n     asynchronous active-low reset
//   pixelx/y    current pixel coordinate (10 bits each)
//   video_on    visible-area flag
//   frame_tick  one-cycle pulse per frame; loads the digit snapshot and
//               advances the blink counter
//   digits      BCD fields, field f = digits[8f+7:8f] = {tens, units}
//   edit_en     edit mode active
//   edit_sel    index of the field being edited
//   rom_addr    {char_code[6:0], glyph_row[3:0]}
//   bit_col     glyph column within the ROM byte
//   font_size   glyph scale exponent (SCALE_LOG2)
//   color_addr  colour index
//   char_valid  pixel lies in a drawn character cell
module clock_text_overlay #(
    parameter int         N_FIELDS     = 3,
    parameter int         X0           = 100,
    parameter int         Y0           = 3,
    parameter int         SCALE_LOG2   = 0,
    parameter int         BLINK_FRAMES = 30,
    parameter logic [3:0] COLOR_NORM   = 4'd2,
    parameter logic [3:0] COLOR_EDIT   = 4'd4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [9:0]              pixelx,
    input  logic [9:0]              pixely,
    input  logic                    video_on,
    input  logic                    frame_tick,
    input  logic [8*N_FIELDS-1:0]   digits,
    input  logic                    edit_en,
    input  logic [2:0]              edit_sel,
    output logic [10:0]             rom_addr,
    output logic [2:0]              bit_col,
    output logic [1:0]              font_size,
    output logic [3:0]              color_addr,
    output logic                    char_valid
);

    localparam int N_CELLS    = 3 * N_FIELDS - 1;
    localparam int CELL_W     = 8 << SCALE_LOG2;
    localparam int CELL_H     = 16 << SCALE_LOG2;
    localparam int X_END      = X0 + N_CELLS * CELL_W;
    localparam int Y_END      = Y0 + CELL_H;
    localparam int CELL_SHIFT = 3 + SCALE_LOG2;
    localparam int CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // ---------------- digit snapshot ----------------
    logic [8*N_FIELDS-1:0] digits_q_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            digits_q_reg <= '0;
        else if (frame_tick)
            digits_q_reg <= digits;
    end

    // ---------------- blink state ----------------
    logic             edit_en_d_reg;
    logic [CNT_W-1:0] blink_cnt_reg;
    logic             blink_phase_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edit_en_d_reg   <= 1'b0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            edit_en_d_reg <= edit_en;
            // Entering edit mode restarts with the digits visible; this takes
            // priority over a frame_tick in the same cycle.
            if (edit_en && !edit_en_d_reg) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= 1'b0;
            end else if (frame_tick && edit_en) begin
                if (blink_cnt_reg == CNT_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 1: geometry ----------------
    logic [11:0] px_ext;
    logic [11:0] py_ext;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        in_region_next;

    assign px_ext = {2'b00, pixelx};
    assign py_ext = {2'b00, pixely};
    assign dx     = pixelx - 10'(X0);
    assign dy     = pixely - 10'(Y0);
    assign in_region_next = (px_ext >= 12'(X0)) && (px_ext < 12'(X_END)) &&
                            (py_ext >= 12'(Y0)) && (py_ext < 12'(Y_END));

    logic       in_region_s1_reg;
    logic       video_on_s1_reg;
    logic [4:0] cell_s1_reg;
    logic [3:0] glyph_row_s1_reg;
    logic [2:0] bit_col_s1_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_region_s1_reg <= 1'b0;
            video_on_s1_reg  <= 1'b0;
            cell_s1_reg      <= '0;
            glyph_row_s1_reg <= '0;
            bit_col_s1_reg   <= '0;
        end else begin
            in_region_s1_reg <= in_region_next;
            video_on_s1_reg  <= video_on;
            cell_s1_reg      <= 5'(dx >> CELL_SHIFT);
            glyph_row_s1_reg <= 4'(dy >> SCALE_LOG2);
            bit_col_s1_reg   <= 3'(dx >> SCALE_LOG2);
        end
    end

    // ---------------- per-cell character table ----------------
    // One entry per possible cell index, so the stage-1 cell number selects
    // directly. Indices past the last cell are never reached inside the region.
    logic [6:0] cell_code  [0:31];
    logic       cell_digit [0:31];
    logic [2:0] cell_field [0:31];

    for (genvar gi = 0; gi < 32; gi++) begin : g_cell
        if (gi < N_CELLS && (gi % 3) != 2) begin : g_digit
            logic [3:0] nib;
            if ((gi % 3) == 0) begin : g_tens
                assign nib = digits_q_reg[8*(gi/3)+4 +: 4];
            end else begin : g_units
                assign nib = digits_q_reg[8*(gi/3) +: 4];
            end
            assign cell_code[gi]  = (nib > 4'd9) ? 7'h3F : (7'h30 + {3'b000, nib});
            assign cell_digit[gi] = 1'b1;
            assign cell_field[gi] = 3'(gi / 3);
        end else begin : g_colon
            assign cell_code[gi]  = 7'h3A;
            assign cell_digit[gi] = 1'b0;
            assign cell_field[gi] = 3'(gi / 3);
        end
    end

    // ---------------- stage 2: character, colour, valid ----------------
    logic        edit_hit;
    logic        visible;
    logic [10:0] rom_addr_next;
    logic [2:0]  bit_col_next;
    logic [3:0]  color_next;

    always_comb begin
        edit_hit = edit_en && ({1'b0, edit_sel} < 4'(N_FIELDS)) &&
                   cell_digit[cell_s1_reg] && (cell_field[cell_s1_reg] == edit_sel);
        visible  = in_region_s1_reg && video_on_s1_reg && !(edit_hit && blink_phase_reg);
        rom_addr_next = '0;
        bit_col_next  = '0;
        color_next    = '0;
        if (visible) begin
            rom_addr_next = {cell_code[cell_s1_reg], glyph_row_s1_reg};
            bit_col_next  = bit_col_s1_reg;
            color_next    = edit_hit ? COLOR_EDIT : COLOR_NORM;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr   <= '0;
            bit_col    <= '0;
            color_addr <= '0;
            char_valid <= 1'b0;
            font_size  <= '0;
        end else begin
            rom_addr   <= rom_addr_next;
            bit_col    <= bit_col_next;
            color_addr <= color_next;
            char_valid <= visible;
            font_size  <= 2'(SCALE_LOG2);
        end
    end

endmodule

// File: tb/tb_clock_text_overlay.sv
module tb_clock_text_overlay;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  pixelx, pixely;
    logic        video_on, frame_tick;
    logic [23:0] digits;
    logic        edit_en;
    logic [2:0]  edit_sel;

    logic [10:0] rom0, rom1;
    logic [2:0]  bc0, bc1;
    logic [1:0]  fs0, fs1;
    logic [3:0]  col0, col1;
    logic        v0, v1;

    always #5 clk = ~clk;

    // Default geometry, short blink period.
    clock_text_overlay #(.BLINK_FRAMES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .pixelx(pixelx), .pixely(pixely),
        .video_on(video_on), .frame_tick(frame_tick), .digits(digits),
        .edit_en(edit_en), .edit_sel(edit_sel), .rom_addr(rom0), .bit_col(bc0),
        .font_size(fs0), .color_addr(col0), .char_valid(v0));

    // Double-size glyphs.
    clock_text_overlay #(.SCALE_LOG2(1), .BLINK_FRAMES(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .pixelx(pixelx), .pixely(pixely),
        .video_on(video_on), .frame_tick(frame_tick), .digits(digits),
        .edit_en(edit_en), .edit_sel(edit_sel), .rom_addr(rom1), .bit_col(bc1),
        .font_size(fs1), .color_addr(col1), .char_valid(v1));

    function automatic logic [31:0] pk(input logic v, input logic [3:0] c,
                                       input logic [2:0] b, input logic [10:0] r);
        return {13'b0, v, c, b, r};
    endfunction

    logic [31:0] obs0, obs1;
    assign obs0 = pk(v0, col0, bc0, rom0);
    assign obs1 = pk(v1, col1, bc1, rom1);

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       tag;
        bit          dsel;
        logic [31:0] exp;
        int          due;
    } sb_t;

    sb_t sb[$];

    // Compare each expected entry when its pixel leaves the pipeline.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            check(e.tag, e.dsel ? obs1 : obs0, e.exp);
            $display("px %s dut%0d obs=%h exp=%h", e.tag, e.dsel, e.dsel ? obs1 : obs0, e.exp);
        end
    end

    task automatic px(input int x, input int y, input bit von, input bit dsel,
                      input logic [31:0] exp, input string tag);
        sb_t e;
        @(posedge clk); #1;
        pixelx   = 10'(x);
        pixely   = 10'(y);
        video_on = von;
        e.tag  = tag;
        e.dsel = dsel;
        e.exp  = exp;
        e.due  = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            video_on = 1'b0;
            pixelx   = '0;
            pixely   = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
    endtask

    // Edited field 1 (cells 3,4), colon cell 5, unedited cell 0.
    task automatic frame_chk(input bit blank, input string pre);
        px(124, 3, 1, 0, blank ? 32'h0 : pk(1, 4, 0, 11'h330), {pre, "_tens"});
        px(132, 3, 1, 0, blank ? 32'h0 : pk(1, 4, 0, 11'h340), {pre, "_units"});
        px(140, 3, 1, 0, pk(1, 2, 0, 11'h3A0), {pre, "_colon"});
        px(100, 3, 1, 0, pk(1, 2, 0, 11'h310), {pre, "_field0"});
        idle(3);
    endtask

    initial begin
        reset_n    = 1'b0;
        pixelx     = '0;
        pixely     = '0;
        video_on   = 1'b0;
        frame_tick = 1'b0;
        digits     = '0;
        edit_en    = 1'b0;
        edit_sel   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out0", obs0, 32'h0);
        check("rst_fs1", 32'(fs1), 32'h0);
        reset_n = 1'b1;
        #1 check("fs1_pre_clk", 32'(fs1), 32'h0);
        @(posedge clk); #1 check("fs1_post_clk", 32'(fs1), 32'h1);

        // Basic rendering.
        digits = 24'h563412;
        tick();
        px(100, 3, 1, 0, pk(1, 2, 0, 11'h310), "cell0_origin");
        px(127, 10, 1, 0, pk(1, 2, 3, 11'h337), "cell3_mid");
        px(118, 5, 1, 0, pk(1, 2, 2, 11'h3A2), "colon");
        px(99, 3, 1, 0, 32'h0, "left_edge");
        px(164, 3, 1, 0, 32'h0, "right_edge");
        px(100, 19, 1, 0, 32'h0, "bottom_edge");
        px(100, 3, 0, 0, 32'h0, "video_off");
        px(163, 18, 1, 0, pk(1, 2, 7, 11'h36F), "last_pixel");
        px(116, 3, 1, 1, pk(1, 2, 0, 11'h320), "s1_cell1");
        px(131, 34, 1, 1, pk(1, 2, 7, 11'h32F), "s1_last_row");
        px(131, 35, 1, 1, 32'h0, "s1_below");
        idle(3);

        // Snapshot only on frame_tick.
        digits = 24'h000000;
        px(100, 3, 1, 0, pk(1, 2, 0, 11'h310), "no_tick");
        idle(3);
        tick();
        px(100, 3, 1, 0, pk(1, 2, 0, 11'h300), "after_tick");
        idle(2);
        digits = 24'h5634A0;
        tick();
        px(100, 3, 1, 0, pk(1, 2, 0, 11'h3F0), "bcd_invalid");
        px(108, 3, 1, 0, pk(1, 2, 0, 11'h300), "bcd_units0");
        idle(2);
        digits = 24'h563412;
        tick();
        idle(3);

        // Blink on field 1.
        edit_sel = 3'd1;
        edit_en  = 1'b1;
        idle(3);
        frame_chk(1'b0, "f0");
        tick();
        frame_chk(1'b0, "f1");
        tick();
        frame_chk(1'b1, "f2");
        tick();
        frame_chk(1'b1, "f3");
        edit_sel = 3'd5;
        idle(2);
        px(124, 3, 1, 0, pk(1, 2, 0, 11'h330), "sel5_tens");
        px(132, 3, 1, 0, pk(1, 2, 0, 11'h340), "sel5_units");
        idle(3);
        edit_sel = 3'd1;
        idle(2);
        px(124, 3, 1, 0, 32'h0, "pre_rst_blank");
        idle(3);

        // Asynchronous reset mid-line while blinked off.
        @(posedge clk); #1;
        pixelx   = 10'd100;
        pixely   = 10'd3;
        video_on = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_out", obs0, pk(1, 2, 0, 11'h310));
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_out0", obs0, 32'h0);
        check("async_rst_out1", obs1, 32'h0);
        check("async_rst_fs1", 32'(fs1), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        px(100, 3, 1, 0, pk(1, 2, 0, 11'h300), "post_rst_zero");
        idle(2);
        tick();
        px(124, 3, 1, 0, pk(1, 4, 0, 11'h330), "post_rst_edit_tens");
        px(132, 3, 1, 0, pk(1, 4, 0, 11'h340), "post_rst_edit_units");
        idle(4);

        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
